// File: rtl/star_scan.sv
// rtl/star_scan.sv - raster scan of the frame buffer for the first star-coloured pixel
// Optional resume-after-find support is enabled with STAR_SCAN_RESUME_EN.
module star_scan #(
    parameter int              xSz      = 8,
    parameter int              ySz      = 7,
    parameter int              colSz    = 4,
    parameter int              WIDTH    = 160,
    parameter int              HEIGHT   = 120,
    parameter logic [colSz-1:0] STAR_COL = 4'hF
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             goScan,
`ifdef STAR_SCAN_RESUME_EN
    input  logic             resumeScan,
`endif
    input  logic [colSz-1:0] pixVal,
    output logic [14:0]      addressRead,
    output logic [xSz-1:0]   xOut,
    output logic [ySz-1:0]   yOut,
    output logic             starFound,
    output logic             doneScan,
    output logic             busy
);

    localparam logic [xSz-1:0] X_LAST = xSz'(WIDTH - 1);
    localparam logic [ySz-1:0] Y_LAST = ySz'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} state_t;

    state_t         state, state_nxt;
    logic [xSz-1:0] x, x_d;
    logic [ySz-1:0] y, y_d;
    logic           v_d, last_d, issuing;
    logic           resume_req;
    logic           at_last, go_start, resume_go, star_hit, frame_end;

`ifdef STAR_SCAN_RESUME_EN
    assign resume_req = resumeScan;
`else
    assign resume_req = 1'b0;
`endif

    assign at_last   = (x == X_LAST) && (y == Y_LAST);
    assign go_start  = (state != SCAN) && goScan;
    assign resume_go = (state == FOUND) && !goScan && resume_req;
    assign star_hit  = (state == SCAN) && v_d && (pixVal == STAR_COL);
    assign frame_end = (state == SCAN) && v_d && last_d && !star_hit;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (goScan) state_nxt = SCAN;
            FOUND: begin
                if (goScan)
                    state_nxt = SCAN;
                else if (resume_req)
                    state_nxt = issuing ? SCAN : DONE;
            end
            SCAN: begin
                if (star_hit)
                    state_nxt = FOUND;
                else if (frame_end)
                    state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SCAN);
    end

    // Counters hold on a hit so a resume restarts at the discarded address (found index + 1).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x           <= '0;
            y           <= '0;
            addressRead <= '0;
            x_d         <= '0;
            y_d         <= '0;
            v_d         <= 1'b0;
            last_d      <= 1'b0;
            issuing     <= 1'b0;
            xOut        <= '0;
            yOut        <= '0;
            starFound   <= 1'b0;
            doneScan    <= 1'b0;
        end else if (go_start) begin
            x           <= '0;
            y           <= '0;
            addressRead <= '0;
            v_d         <= 1'b0;
            issuing     <= 1'b1;
            starFound   <= 1'b0;
            doneScan    <= 1'b0;
        end else if (resume_go) begin
            v_d       <= 1'b0;
            starFound <= 1'b0;
            doneScan  <= !issuing;
        end else if (state == SCAN) begin
            if (star_hit) begin
                xOut      <= x_d;
                yOut      <= y_d;
                starFound <= 1'b1;
                v_d       <= 1'b0;
            end else if (frame_end) begin
                doneScan <= 1'b1;
                v_d      <= 1'b0;
            end else begin
                v_d    <= issuing;
                x_d    <= x;
                y_d    <= y;
                last_d <= at_last;
                if (issuing) begin
                    if (at_last) begin
                        issuing <= 1'b0;
                    end else begin
                        addressRead <= addressRead + 15'd1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_star_scan.sv
// tb/tb_star_scan.sv - scoreboard bench for star_scan with a frame-buffer memory model
module tb_star_scan;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        goScan = 1'b0;
    logic        resumeScan = 1'b0;
    logic [3:0]  pixVal;
    logic [14:0] addressRead;
    logic [7:0]  xOut;
    logic [6:0]  yOut;
    logic        starFound, doneScan, busy;

    star_scan dut (
        .clk(clk),
        .resetn(resetn),
        .goScan(goScan),
`ifdef STAR_SCAN_RESUME_EN
        .resumeScan(resumeScan),
`endif
        .pixVal(pixVal),
        .addressRead(addressRead),
        .xOut(xOut),
        .yOut(yOut),
        .starFound(starFound),
        .doneScan(doneScan),
        .busy(busy)
    );

    always #5 clk = ~clk;

    logic [3:0] mem [N];
    always @(posedge clk) pixVal <= mem[addressRead];

    int edge_n = 0;
    always @(posedge clk) edge_n++;

    typedef struct {
        bit is_star;
        int x;
        int y;
        int addr;
        int edge_at;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    int held_x = 0, held_y = 0;
    int found_idx = -1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int first_star(input int from);
        for (int j = from; j < N; j++)
            if (mem[j] == 4'hF) return j;
        return -1;
    endfunction

    // Outcome of scanning from raster index 'from' whose first issue lands on edge base_edge.
    task automatic push_outcome(input int from, input int base_edge);
        exp_t e;
        int j;
        j = first_star(from);
        if (j >= 0) begin
            e.is_star = 1'b1;
            e.x = j % W;
            e.y = j / W;
            e.addr = (j == N - 1) ? N - 1 : j + 1;
            e.edge_at = base_edge + (j - from) + 2;
            held_x = e.x;
            held_y = e.y;
        end else begin
            e.is_star = 1'b0;
            e.x = held_x;
            e.y = held_y;
            e.addr = N - 1;
            e.edge_at = base_edge + (N - 1 - from) + 2;
        end
        found_idx = j;
        sb.push_back(e);
    endtask

    task automatic clear_frame();
        for (int i = 0; i < N; i++) mem[i] = 4'($urandom_range(0, 14));
    endtask

    task automatic start_scan();
        @(negedge clk);
        goScan = 1'b1;
        push_outcome(0, edge_n + 1);
        @(negedge clk);
        goScan = 1'b0;
    endtask

    task automatic resume_scan();
        exp_t e;
        @(negedge clk);
        resumeScan = 1'b1;
        if (found_idx == N - 1) begin
            e.is_star = 1'b0;
            e.x = held_x;
            e.y = held_y;
            e.addr = N - 1;
            e.edge_at = edge_n + 1;
            found_idx = -1;
            sb.push_back(e);
        end else begin
            push_outcome(found_idx + 1, edge_n + 1);
        end
        @(negedge clk);
        resumeScan = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got %0d pending events, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    bit prev_sf = 1'b0, prev_ds = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!resetn) begin
            prev_sf = 1'b0;
            prev_ds = 1'b0;
        end else begin
            check("exclusive", int'(starFound && doneScan), 0);
            check("addr_bound", int'(addressRead <= 15'(N - 1)), 1);
            if ((starFound && !prev_sf) || (doneScan && !prev_ds)) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("star_flag", int'(starFound), int'(e.is_star));
                    check("done_flag", int'(doneScan), int'(!e.is_star));
                    check("x_out", int'(xOut), e.x);
                    check("y_out", int'(yOut), e.y);
                    check("addr_at_event", int'(addressRead), e.addr);
                    check("event_edge", edge_n, e.edge_at);
                    check("busy_at_event", int'(busy), 0);
                end
            end
            prev_sf = starFound;
            prev_ds = doneScan;
        end
    end

    initial begin
        for (int i = 0; i < N; i++) mem[i] = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_addr", int'(addressRead), 0);
        check("rst_x", int'(xOut), 0);
        check("rst_y", int'(yOut), 0);
        check("rst_found", int'(starFound), 0);
        check("rst_done", int'(doneScan), 0);
        check("rst_busy", int'(busy), 0);
        resetn = 1'b1;

        clear_frame(); mem[3 * W + 5] = 4'hF;
        start_scan(); wait_drain(20000);

        clear_frame(); mem[0] = 4'hF;
        start_scan(); wait_drain(20000);

        clear_frame(); mem[N - 1] = 4'hF;
        start_scan(); wait_drain(20000);

        clear_frame();
        start_scan(); wait_drain(20000);

        for (int f = 0; f < 6; f++) begin
            int k;
            clear_frame();
            k = 1 + $urandom_range(0, 2);
            for (int s = 0; s < k; s++) mem[$urandom_range(100, 1499)] = 4'hF;
            start_scan();
            if (f == 0) begin
                repeat (20) @(negedge clk);
                goScan = 1'b1;
                @(negedge clk);
                goScan = 1'b0;
            end
            wait_drain(20000);
        end

        clear_frame(); mem[$urandom_range(1000, 1499)] = 4'hF;
        start_scan();
        repeat (300) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("arst_addr", int'(addressRead), 0);
        check("arst_x", int'(xOut), 0);
        check("arst_y", int'(yOut), 0);
        check("arst_found", int'(starFound), 0);
        check("arst_done", int'(doneScan), 0);
        check("arst_busy", int'(busy), 0);
        sb.delete();
        held_x = 0;
        held_y = 0;
        @(negedge clk);
        resetn = 1'b1;
        start_scan();
        check("restart_addr0", int'(addressRead), 0);
        @(negedge clk);
        check("restart_addr1", int'(addressRead), 1);
        wait_drain(20000);

`ifdef STAR_SCAN_RESUME_EN
        clear_frame(); mem[10] = 4'hF; mem[400] = 4'hF;
        start_scan(); wait_drain(20000);
        resume_scan(); wait_drain(20000);
        resume_scan(); wait_drain(20000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
